keypad_matrix_scanner: RTL
==========================

Name: keypad_matrix_scanner

Overview:
- Input-side counterpart of the multiplexed LED display driver.
- The display drives one digit-select line at a time and pushes segment data out. This block drives one column strobe at a time and reads row returns back from a key matrix.
- Keeps a debounced state for every key and emits one press event per newly pressed key over a valid/ready handshake.
- Sits between the board keypad pins and request/priority logic such as the arbiter demo.

Parameters:
- COLS, 4, number of matrix columns (strobe outputs), >= 2
- ROWS, 4, number of matrix rows (return inputs), >= 2
- SETTLE, 16, cycles each column is strobed before its rows are sampled, >= 3
- DEBOUNCE, 4, consecutive full scans a key must differ from its debounced state before that state flips, >= 1

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- col_n  output  COLS  active-low one-hot column strobe
- rows_n  input  ROWS  raw active-low row returns, asynchronous to clk
- key_map  output  COLS*ROWS  debounced key state, bit k = 1 means pressed
- key_valid  output  1  press event available
- key_code  output  $clog2(COLS*ROWS)  index of the pressed key
- key_ready  input  1  consumer accepts the event

Behaviour:
- Reset, asynchronous on rst low:
  - col_n = ~1 (column 0 strobed); column index 0; settle counter 0.
  - key_map = 0; all debounce counters = 0; pending vector = 0.
  - key_valid = 0; key_code = 0; row synchronizer flops = all ones.
  - Scanning resumes on the first clk edge after rst rises.
- Synchronization:
  - rows_n passes through a 2-flop synchronizer, then is inverted to give active-high rows.
- Column phase:
  - Column c is strobed for exactly SETTLE cycles. Settle counter runs 0..SETTLE-1.
  - On the cycle the counter equals SETTLE-1, the synchronized rows are captured into raw bits c*ROWS+r.
  - On the next edge the counter goes to 0 and col_n moves to column (c+1) mod COLS.
  - Exactly one col_n bit is low at all times; strobe changes only at phase boundaries.
  - One full scan takes COLS*SETTLE cycles. Column COLS-1 wraps to column 0 with no gap.
- Key index: k = col*ROWS + row.
- Debounce, evaluated for every key on the capture cycle of column COLS-1 (end of scan):
  - raw == key_map[k]: counter_k <= 0.
  - raw != key_map[k] and counter_k == DEBOUNCE-1: key_map[k] flips, counter_k <= 0.
  - Otherwise counter_k increments.
  - The counter width holds DEBOUNCE-1. A change is accepted after DEBOUNCE consecutive differing scans.
- Event generation:
  - A 0->1 flip of key_map[k] sets pending[k]. Releases (1->0) generate no event.
  - If pending[k] is already set when key k flips 0->1 again, the events merge; pending stays 1.
- Output register:
  - When key_valid = 0, or key_valid & key_ready, and pending != 0, the lowest set pending index is loaded.
  - On load: key_code <= that index, key_valid <= 1, that pending bit is cleared, all on the same edge.
  - Otherwise a handshake sets key_valid <= 0.
  - Back-to-back events are legal: accept in cycle N, new code valid in cycle N+1.
  - While key_valid & !key_ready, key_code and key_valid hold stable and pending keeps accumulating. No event is ever dropped.
  - A pending set (scan end) and a pending clear (load) in the same cycle both apply, per bit.
- Latency:
  - A key held steadily from before scan S starts is flagged at the end of scan S+DEBOUNCE-1, plus 2 synchronizer cycles of margin inside the settle window.
  - key_valid rises 1 cycle after the pending bit sets when the output register is free.
- Reset mid-operation: all state clears immediately, including any held key_valid and pending events.

Test Plan:
- COLS=4, ROWS=4, SETTLE=4, DEBOUNCE=3, press key row 2 / col 1 (rows_n[2] low while col_n[1] low), hold -> key_map[6] = 1 at the end of the 3rd full scan (48 cycles per 3 scans); key_valid = 1 next cycle with key_code = 6; no event on release.
- Same config, key 6 asserted for only 2 scans then released -> key_map stays 0, key_valid never rises.
- Keys 3 and 9 pressed together, key_ready held high -> key_valid high 2 consecutive cycles, key_code 3 then 9, then key_valid = 0.
- key_ready low for 100 cycles with key 5 event pending -> key_valid = 1 and key_code = 5 stable throughout; key 12 pressed meanwhile is delivered after the ready pulse.
- Strobe check, free-running -> col_n sequence 1110, 1101, 1011, 0111, each exactly 4 cycles, wrapping repeatedly, never two bits low.
- rst driven low while key_valid = 1 and another event pending -> key_valid = 0, key_map = 0, col_n = 1110 asynchronously; no stale event after rst rises.

Source files
------------

// File: rtl/keypad_matrix_scanner.sv
// Key matrix scanner: strobes columns, debounces every key, emits one event per new press.
// Latency: press flagged DEBOUNCE scans after it is first seen; key_valid one cycle after.
// Backpressure: key_valid/key_code hold while !key_ready; further presses queue in pending.
module keypad_matrix_scanner #(
    parameter int COLS     = 4,
    parameter int ROWS     = 4,
    parameter int SETTLE   = 16,
    parameter int DEBOUNCE = 4,
    localparam int NK      = COLS * ROWS,
    localparam int KW      = (NK > 1) ? $clog2(NK) : 1
) (
    input  logic            clk,
    input  logic            rst,
    output logic [COLS-1:0] col_n,
    input  logic [ROWS-1:0] rows_n,
    output logic [NK-1:0]   key_map,
    output logic            key_valid,
    output logic [KW-1:0]   key_code,
    input  logic            key_ready
);
    localparam int CIW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int CW  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [ROWS-1:0] rows_s1, rows_s2, rows;
    logic [CIW-1:0]  col_idx;
    logic [SW-1:0]   settle_cnt;
    logic [NK-1:0]   raw, raw_now;
    logic [CW-1:0]   cnt     [NK];
    logic [CW-1:0]   cnt_nxt [NK];
    logic [NK-1:0]   map_nxt, rise, pending, pend_clr;
    logic [KW-1:0]   low_idx;
    logic            capture, scan_end, out_free, load;

    assign rows     = ~rows_s2;
    assign capture  = (settle_cnt == SW'(SETTLE - 1));
    assign scan_end = capture && (col_idx == CIW'(COLS - 1));
    assign out_free = !key_valid || key_ready;
    assign load     = out_free && (|pending);

    // Splice in the column being captured so the scan-end debounce sees the complete scan.
    always_comb begin
        raw_now = raw;
        for (int c = 0; c < COLS; c++) begin
            if (capture && (col_idx == CIW'(c)))
                raw_now[c*ROWS +: ROWS] = rows;
        end
    end

    always_comb begin
        map_nxt = key_map;
        rise    = '0;
        for (int k = 0; k < NK; k++) begin
            cnt_nxt[k] = cnt[k];
            if (scan_end) begin
                if (raw_now[k] == key_map[k]) begin
                    cnt_nxt[k] = '0;
                end else if (cnt[k] == CW'(DEBOUNCE - 1)) begin
                    map_nxt[k] = raw_now[k];
                    cnt_nxt[k] = '0;
                    rise[k]    = raw_now[k];
                end else begin
                    cnt_nxt[k] = cnt[k] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        low_idx  = '0;
        pend_clr = '0;
        for (int k = NK - 1; k >= 0; k--) begin
            if (pending[k]) low_idx = KW'(k);
        end
        if (load) pend_clr[low_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rows_s1    <= '1;
            rows_s2    <= '1;
            col_n      <= ~{{(COLS-1){1'b0}}, 1'b1};
            col_idx    <= '0;
            settle_cnt <= '0;
            raw        <= '0;
            key_map    <= '0;
            pending    <= '0;
            key_valid  <= 1'b0;
            key_code   <= '0;
            for (int k = 0; k < NK; k++) cnt[k] <= '0;
        end else begin
            rows_s1 <= rows_n;
            rows_s2 <= rows_s1;
            if (capture) begin
                raw        <= raw_now;
                settle_cnt <= '0;
                col_n      <= {col_n[COLS-2:0], col_n[COLS-1]};
                col_idx    <= (col_idx == CIW'(COLS - 1)) ? '0 : col_idx + 1'b1;
            end else begin
                settle_cnt <= settle_cnt + 1'b1;
            end
            key_map <= map_nxt;
            for (int k = 0; k < NK; k++) cnt[k] <= cnt_nxt[k];
            pending <= (pending & ~pend_clr) | rise;
            if (load) begin
                key_valid <= 1'b1;
                key_code  <= low_idx;
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end
endmodule
